// File: rtl/divider_pattern_gen.sv
// divider_pattern_gen
// Draws the vertical divider marks of the tug-of-war playfield. Marks are
// off, solid, dashed or scrolling-dashed. A frame-counted flash sequencer
// blinks the marks on a point/win event. The pixel is registered, so it
// lags hpos/vpos by one clock.
module divider_pattern_gen #(
  parameter int          H_CENTER      = 320,
  parameter int          MARK_W        = 1,
  parameter int          NUM_MARKS     = 1,
  parameter int          MARK_SPACING  = 100,
  parameter int          DASH_ON       = 4,
  parameter int          DASH_PERIOD   = 8,
  parameter int          SCROLL_FRAMES = 4,
  parameter logic [7:0]  MARK_COLOR    = 8'hFF,
  parameter logic [7:0]  FLASH_COLOR   = 8'hE0,
  parameter int          FLASH_FRAMES  = 15,
  parameter int          FLASH_COUNT   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       en,
  input  logic       frame_start,
  input  logic [1:0] mode,
  input  logic       flash_req,
  output logic [7:0] out_color,
  output logic       flash_busy
);

  localparam int OFF_W = $clog2(DASH_PERIOD);
  localparam logic [OFF_W-1:0] DASH_ON_L   = OFF_W'(DASH_ON);
  localparam logic [7:0]       SCROLL_LAST = 8'(SCROLL_FRAMES - 1);
  localparam logic [7:0]       PHASE_LAST  = 8'(FLASH_FRAMES - 1);
  localparam logic [3:0]       PAIRS_LAST  = 4'(FLASH_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t           state_q;
  logic [7:0]       phaseFrm_q;
  logic [3:0]       pairs_q;
  logic             busy_q;
  logic [OFF_W-1:0] offset_q, offset_d;
  logic [7:0]       scrollFrm_q, scrollFrm_d;
  logic [7:0]       outColor_q, outColor_d;

  logic signed [10:0]   hposS;
  logic [NUM_MARKS-1:0] markHit;
  logic                 anyHit;
  logic [9:0]           dashSum;
  logic                 dashHit;
  logic                 vertHit;

  assign hposS = signed'({1'b0, hpos});

  // Each mark owns a fixed column window; marks placed off the visible
  // 0..639 range are tied off so they can never light a pixel.
  for (genvar k = 0; k < NUM_MARKS; k++) begin : gMark
    localparam int XK = H_CENTER + (k - (NUM_MARKS - 1) / 2) * MARK_SPACING;
    if ((XK >= 0) && (XK <= 639)) begin : gVisible
      localparam logic signed [10:0] XS = 11'(XK);
      localparam logic signed [10:0] XE = 11'(XK + MARK_W);
      assign markHit[k] = (hposS >= XS) && (hposS < XE);
    end else begin : gHidden
      assign markHit[k] = 1'b0;
    end
  end

  assign anyHit  = |markHit;
  assign dashSum = vpos + 10'(offset_q);
  assign dashHit = dashSum[OFF_W-1:0] < DASH_ON_L;

  // Vertical pattern selection; the scroll offset applies to both dashed modes.
  always_comb begin
    vertHit = 1'b0;
    case (mode)
      2'd0:    vertHit = 1'b0;
      2'd1:    vertHit = 1'b1;
      default: vertHit = dashHit;
    endcase
  end

  // Pixel colour: flash ON forces solid flash colour, flash OFF blanks,
  // otherwise the normal mode-dependent pattern.
  always_comb begin
    outColor_d = 8'h00;
    case (state_q)
      ON:      if (anyHit) outColor_d = FLASH_COLOR;
      OFF:     outColor_d = 8'h00;
      default: if (anyHit && vertHit) outColor_d = MARK_COLOR;
    endcase
  end

  // Scroll stepping only runs in mode 3; other modes freeze offset and
  // frame count so returning to mode 3 picks up where it left off.
  always_comb begin
    offset_d    = offset_q;
    scrollFrm_d = scrollFrm_q;
    if ((mode == 2'd3) && frame_start) begin
      if (scrollFrm_q == SCROLL_LAST) begin
        scrollFrm_d = 8'd0;
        offset_d    = offset_q + OFF_W'(1);
      end else begin
        scrollFrm_d = scrollFrm_q + 8'd1;
      end
    end
  end

  // Scroll state registers, independent of the pixel enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q    <= '0;
      scrollFrm_q <= 8'd0;
    end else begin
      offset_q    <= offset_d;
      scrollFrm_q <= scrollFrm_d;
    end
  end

  // Flash sequencer: alternating ON/OFF phases of FLASH_FRAMES frames each,
  // FLASH_COUNT pairs, with a registered busy flag. Requests while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      phaseFrm_q <= 8'd0;
      pairs_q    <= 4'd0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flash_req) begin
            state_q    <= ON;
            phaseFrm_q <= 8'd0;
            pairs_q    <= 4'd0;
            busy_q     <= 1'b1;
          end
        end
        ON: begin
          if (frame_start) begin
            if (phaseFrm_q == PHASE_LAST) begin
              phaseFrm_q <= 8'd0;
              state_q    <= OFF;
            end else begin
              phaseFrm_q <= phaseFrm_q + 8'd1;
            end
          end
        end
        OFF: begin
          if (frame_start) begin
            if (phaseFrm_q == PHASE_LAST) begin
              phaseFrm_q <= 8'd0;
              if (pairs_q == PAIRS_LAST) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else begin
                pairs_q <= pairs_q + 4'd1;
                state_q <= ON;
              end
            end else begin
              phaseFrm_q <= phaseFrm_q + 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Output pixel register; holds while the pixel enable is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outColor_q <= 8'h00;
    end else if (en) begin
      outColor_q <= outColor_d;
    end
  end

  assign out_color  = outColor_q;
  assign flash_busy = busy_q;

endmodule

// File: tb/tb_divider_pattern_gen.sv
// tb_divider_pattern_gen
// Three instances share one stimulus stream: a single centre mark, three
// 2-pixel marks around column 320, and three marks around 600 whose right
// mark lands off-screen. A behavioural model predicts each cycle's pixels.
module tb_divider_pattern_gen;

  localparam int FF = 2;
  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hpos, vpos;
  logic       en, frameStart, flashReq;
  logic [1:0] mode;
  logic [7:0] colorA, colorB, colorC;
  logic       busyA, busyB, busyC;

  int assertCount = 0;
  int failCount   = 0;

  // Model state
  int mState, mPhase, mPairs, mOffset, mScroll;
  logic [7:0] lastA, lastB, lastC;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       busy;
  } exp_t;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  divider_pattern_gen #(.H_CENTER(320), .MARK_W(1), .NUM_MARKS(1),
                        .FLASH_FRAMES(FF), .FLASH_COUNT(FC)) dutA (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .en(en),
    .frame_start(frameStart), .mode(mode), .flash_req(flashReq),
    .out_color(colorA), .flash_busy(busyA));

  divider_pattern_gen #(.H_CENTER(320), .MARK_W(2), .NUM_MARKS(3),
                        .FLASH_FRAMES(FF), .FLASH_COUNT(FC)) dutB (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .en(en),
    .frame_start(frameStart), .mode(mode), .flash_req(flashReq),
    .out_color(colorB), .flash_busy(busyB));

  divider_pattern_gen #(.H_CENTER(600), .MARK_W(2), .NUM_MARKS(3),
                        .FLASH_FRAMES(FF), .FLASH_COUNT(FC)) dutC (
    .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos), .en(en),
    .frame_start(frameStart), .mode(mode), .flash_req(flashReq),
    .out_color(colorC), .flash_busy(busyC));

  // Counts every comparison and reports any disagreement
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected pixel for a mark layout given pre-edge model state
  function automatic logic [7:0] modelColor(int hc, int nm, int mw, int h, int v, int m);
    bit hit = 0;
    bit vhit;
    for (int k = 0; k < nm; k++) begin
      int xk = hc + (k - (nm - 1) / 2) * 100;
      if (xk >= 0 && xk <= 639 && h >= xk && h < xk + mw) hit = 1;
    end
    if (m == 0)      vhit = 0;
    else if (m == 1) vhit = 1;
    else             vhit = (((v + mOffset) % 1024) % 8) < 4;
    if (mState == 1) return hit ? 8'hE0 : 8'h00;
    if (mState == 2) return 8'h00;
    return (hit && vhit) ? 8'hFF : 8'h00;
  endfunction

  task automatic modelReset();
    mState = 0; mPhase = 0; mPairs = 0; mOffset = 0; mScroll = 0;
    lastA = 8'h00; lastB = 8'h00; lastC = 8'h00;
  endtask

  // Advances the model across one clock edge
  task automatic modelStep(input int m, input bit fs, input bit fr);
    if (m == 3 && fs) begin
      if (mScroll == 3) begin
        mScroll = 0;
        mOffset = (mOffset + 1) % 8;
      end else mScroll++;
    end
    case (mState)
      0: if (fr) begin mState = 1; mPhase = 0; mPairs = 0; end
      1: if (fs) begin
           if (mPhase == FF - 1) begin mPhase = 0; mState = 2; end
           else mPhase++;
         end
      2: if (fs) begin
           if (mPhase == FF - 1) begin
             mPhase = 0;
             if (mPairs == FC - 1) mState = 0;
             else begin mPairs++; mState = 1; end
           end else mPhase++;
         end
      default: mState = 0;
    endcase
  endtask

  // Drives one pixel cycle, queues the prediction and checks it after the edge
  task automatic applyStimulus(input int h, input int v, input int m,
                               input bit fs, input bit fr, input bit e);
    exp_t ex, got;
    @(negedge clk);
    hpos = 10'(h); vpos = 10'(v); mode = 2'(m);
    frameStart = fs; flashReq = fr; en = e;
    if (e) begin
      lastA = modelColor(320, 1, 1, h, v, m);
      lastB = modelColor(320, 3, 2, h, v, m);
      lastC = modelColor(600, 3, 2, h, v, m);
    end
    modelStep(m, fs, fr);
    ex.a = lastA; ex.b = lastB; ex.c = lastC; ex.busy = (mState != 0);
    sbQ.push_back(ex);
    @(posedge clk);
    #1;
    got = sbQ.pop_front();
    checkOutput($sformatf("colorA h=%0d v=%0d m=%0d", h, v, m), colorA, got.a);
    checkOutput($sformatf("colorB h=%0d v=%0d m=%0d", h, v, m), colorB, got.b);
    checkOutput($sformatf("colorC h=%0d v=%0d m=%0d", h, v, m), colorC, got.c);
    checkOutput("busyA", {7'd0, busyA}, {7'd0, got.busy});
    checkOutput("busyB", {7'd0, busyB}, {7'd0, got.busy});
    checkOutput("busyC", {7'd0, busyC}, {7'd0, got.busy});
  endtask

  initial begin
    rst = 1'b1; hpos = '0; vpos = '0; en = 1'b0; frameStart = 1'b0;
    flashReq = 1'b0; mode = 2'd0;
    modelReset();
    #12;
    checkOutput("resetColorA", colorA, 8'h00);
    checkOutput("resetBusyA", {7'd0, busyA}, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Single-mark sweep across the centre column
    for (int h = 318; h <= 322; h++) applyStimulus(h, 10, 1, 0, 0, 1);

    // Enable low holds the last pixel
    applyStimulus(320, 10, 1, 0, 0, 1);
    applyStimulus(0, 10, 1, 0, 0, 0);
    applyStimulus(5, 10, 1, 0, 0, 0);

    // Dashed pattern down the centre column
    for (int v = 0; v < 16; v++) applyStimulus(320, v, 2, 0, 0, 1);

    // Scrolling: eight frames in mode 3 advance the offset by two
    for (int f = 0; f < 8; f++) begin
      applyStimulus(320, 6, 3, 1, 0, 1);
      applyStimulus(320, 6, 3, 0, 0, 1);
    end
    applyStimulus(320, 6, 2, 0, 0, 1);
    applyStimulus(320, 6, 2, 1, 0, 1);
    applyStimulus(320, 6, 3, 0, 0, 1);
    for (int v = 0; v < 8; v++) applyStimulus(320, v, 3, 0, 0, 1);

    // Column sweeps around every candidate mark position
    for (int h = 215; h <= 225; h++) applyStimulus(h, 10, 1, 0, 0, 1);
    for (int h = 315; h <= 325; h++) applyStimulus(h, 10, 1, 0, 0, 1);
    for (int h = 415; h <= 425; h++) applyStimulus(h, 10, 1, 0, 0, 1);
    for (int h = 495; h <= 505; h++) applyStimulus(h, 10, 1, 0, 0, 1);
    for (int h = 595; h <= 605; h++) applyStimulus(h, 10, 1, 0, 0, 1);
    for (int h = 695; h <= 705; h++) applyStimulus(h, 10, 1, 0, 0, 1);

    // Flash in mode 0, started on a frame_start cycle, with a stray request mid-sequence
    applyStimulus(320, 10, 0, 1, 1, 1);
    for (int f = 0; f < 10; f++) begin
      applyStimulus(320, 10, 0, 1, 0, 1);
      applyStimulus(321, 10, 0, 0, (f == 3), 1);
      applyStimulus(320, 10, 0, 0, 0, 1);
    end

    // Flash again, then reset during ON with the pixel enable low
    applyStimulus(320, 10, 0, 0, 1, 1);
    applyStimulus(320, 10, 0, 0, 0, 1);
    applyStimulus(0, 10, 0, 0, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstColorA", colorA, 8'h00);
    checkOutput("asyncRstColorB", colorB, 8'h00);
    checkOutput("asyncRstBusyA", {7'd0, busyA}, 8'h00);
    modelReset();
    @(negedge clk);
    rst = 1'b0;

    // Offset back to zero after reset
    for (int v = 0; v < 8; v++) applyStimulus(320, v, 2, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
